// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a uart_send transmitter through a
// strobe/IDLE handshake, with overflow and missing-acknowledge flags.
module uart_tx_fifo #(
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        WR_DATA,
  input  logic              WR_EN,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERFLOW,
  output logic              ACK_ERR,
  output logic [7:0]        TX_DATA,
  output logic              TX_DATA_READY,
  input  logic              TX_IDLE
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_WAIT, S_STROBE, S_BUSY, S_DONE} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [TMO_W-1:0]  tmo_cnt;
  state_t            state, state_nxt;
  logic              push, pop, tmo_hit;

  // Flags come from the registered occupancy only, so a same-cycle pop
  // never makes room for a write and nothing falls through.
  assign FULL  = (count == (ADDR_W+1)'(DEPTH));
  assign EMPTY = (count == '0);
  assign COUNT = count;

  assign push    = WR_EN & ~FULL;
  assign pop     = (state == S_WAIT) & TX_IDLE & ~EMPTY;
  assign tmo_hit = (state == S_BUSY) & TX_IDLE & (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  // The strobe is exactly the single cycle spent in S_STROBE.
  assign TX_DATA_READY = (state == S_STROBE);

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= WR_DATA;
  end

  // Pointers and occupancy; pointers wrap naturally at ADDR_W bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Sticky error flags and the output byte, which holds until the next pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW <= 1'b0;
      ACK_ERR  <= 1'b0;
      TX_DATA  <= 8'h00;
    end else begin
      if (WR_EN && FULL) OVERFLOW <= 1'b1;
      if (tmo_hit)       ACK_ERR  <= 1'b1;
      if (pop)           TX_DATA  <= mem[rd_ptr];
    end
  end

  // Acknowledge timeout: cleared during the strobe, counts busy cycles with IDLE still high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                               tmo_cnt <= '0;
    else if (state == S_STROBE)            tmo_cnt <= '0;
    else if (state == S_BUSY && TX_IDLE)   tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_WAIT;
    else     state <= state_nxt;
  end

  // FSM next state: strobe, wait for IDLE to fall (or time out), wait for it to rise.
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:   if (pop) state_nxt = S_STROBE;
      S_STROBE: state_nxt = S_BUSY;
      S_BUSY: begin
        if (!TX_IDLE)     state_nxt = S_DONE;
        else if (tmo_hit) state_nxt = S_WAIT;
      end
      S_DONE:   if (TX_IDLE) state_nxt = S_WAIT;
      default:  state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: ADDR_W, 4, log2 of FIFO depth (depth 16 bytes).
REQ-002 Parameter: ACK_TIMEOUT, 1023, max CLK cycles to wait for TX_IDLE to fall after a strobe.
REQ-003 CLK  input  1  single system clock, all state on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 WR_DATA  input  8  byte to enqueue.
REQ-006 WR_EN  input  1  enqueue request, one byte per cycle while high.
REQ-007 FULL  output  1  FIFO holds 2^ADDR_W bytes.
REQ-008 EMPTY  output  1  FIFO holds 0 bytes.
REQ-009 COUNT  output  ADDR_W+1  current occupancy.
REQ-010 OVERFLOW  output  1  sticky: a write was dropped.
REQ-011 ACK_ERR  output  1  sticky: uart_send never went busy after a strobe.
REQ-012 TX_DATA  output  8  byte to uart_send DATA.
REQ-013 TX_DATA_READY  output  1  one-cycle strobe to uart_send DATA_READY.
REQ-014 TX_IDLE  input  1  from uart_send IDLE.

Function
REQ-015 Storage: circular buffer, ADDR_W-bit read/write pointers wrapping 15->0, COUNT as separate (ADDR_W+1)-bit register.
REQ-016 Push accepted when WR_EN=1 and FULL=0; byte written at write pointer, pointer+1.
REQ-017 WR_EN=1 while FULL=1: byte dropped, no state change except OVERFLOW<=1; FULL judged on registered COUNT even if a pop occurs same cycle.
REQ-018 Simultaneous push and pop: both pointers advance, COUNT unchanged.
REQ-019 FULL, EMPTY derived from registered COUNT; no fall-through (written byte poppable earliest next cycle).
REQ-020 FSM states: S_WAIT, S_STROBE, S_BUSY, S_DONE.
REQ-021 S_WAIT: if TX_IDLE=1 and EMPTY=0 -> S_STROBE; same edge loads TX_DATA from head, advances read pointer, decrements COUNT (unless simultaneous push), sets TX_DATA_READY=1.
REQ-022 S_STROBE: lasts exactly one cycle; TX_DATA_READY cleared on exit; -> S_BUSY, timeout counter cleared.
REQ-023 S_BUSY: TX_IDLE=0 -> S_DONE; else counter+1; counter reaching ACK_TIMEOUT -> S_WAIT with ACK_ERR<=1.
REQ-024 S_DONE: TX_IDLE=1 -> S_WAIT; no timeout.
REQ-025 TX_DATA held stable from strobe until next strobe.
REQ-026 Latency: byte written into empty FIFO with FSM in S_WAIT and TX_IDLE=1 -> TX_DATA_READY high starting the next rising edge after the storing edge, for exactly 1 cycle.
REQ-027 Back-to-back bytes: next strobe no earlier than 1 cycle after TX_IDLE returns high; never more than one strobe per uart_send frame.
REQ-028 TX_IDLE=0 in S_WAIT: no strobe; FIFO continues accepting writes.

Reset
REQ-029 RST=1 immediately: pointers, COUNT, timeout counter=0; FSM=S_WAIT; EMPTY=1; FULL, OVERFLOW, ACK_ERR, TX_DATA_READY=0; TX_DATA=8'h00.
REQ-030 Reset mid-transfer discards all queued bytes; no strobe issued until after RST deasserts and a new write occurs.
REQ-031 Storage array not reset; contents unobservable while EMPTY=1.

Verification
REQ-032 Single byte: write 8'hAA with TX_IDLE=1 -> TX_DATA=8'hAA, TX_DATA_READY 1 cycle, one edge after store; COUNT 1->0.
REQ-033 Burst: write 8'h01..8'h05 consecutively, model uart_send (IDLE low 100 cycles per byte) -> exactly 5 strobes in order 01..05, each after IDLE rises; EMPTY=1 at end.
REQ-034 Fill/overflow: TX_IDLE=0, write 17 bytes -> FULL=1 after 16, COUNT=16, 17th dropped, OVERFLOW=1; release TX_IDLE -> 16 bytes out, first 16 values only.
REQ-035 Wrap: 3 rounds of 10 bytes with drain -> pointer wrap, byte order and COUNT correct throughout.
REQ-036 Timeout: TX_IDLE held 1 after strobe -> ACK_ERR=1 after ACK_TIMEOUT cycles, FSM back in S_WAIT, next byte strobed.
REQ-037 Reset mid-burst: RST pulse with 6 bytes queued -> EMPTY=1, COUNT=0, TX_DATA_READY=0, no further strobes.
